vc_pmem_arbiter: RTL and testbench
==================================

VC_PMEM_ARBITER -- requirements
Module: vc_pmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive arbitration losses for a pending VC writeback before it is forced to win.
REQ-002 The block SHALL have parameter IDLE_THRESH, default 8: idle cycles before a scrub pulse is issued.
REQ-003 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port l2_read, input, 1: L2 line-fill request, held until l2_ack.
REQ-006 Port l2_addr, input, 16: L2 fill address.
REQ-007 Port l2_rdata, output, 128: fill data, driven from pmem_rdata.
REQ-008 Port l2_ack, output, 1: fill-complete pulse.
REQ-009 Port vc_req, input, 1: VC dirty-line writeback request, held until vc_ack.
REQ-010 Port vc_addr, input, 16: writeback address.
REQ-011 Port vc_wdata, input, 128: writeback data.
REQ-012 Port vc_ack, output, 1: writeback-complete pulse.
REQ-013 Port scrub_go, output, 1: one-cycle pulse telling the VC to start cleaning a dirty entry.
REQ-014 Port pmem_read, output, 1: memory read strobe.
REQ-015 Port pmem_write, output, 1: memory write strobe.
REQ-016 Port pmem_addr, output, 16: memory address.
REQ-017 Port pmem_wdata, output, 128: memory write data.
REQ-018 Port pmem_resp, input, 1: memory completion pulse.
REQ-019 Port pmem_rdata, input, 128: memory read data.

Function
REQ-020 The FSM SHALL have three states, IDLE, L2_RD and VC_WB, with one owner at a time.
REQ-021 IDLE arbitration with only l2_read set SHALL go to L2_RD.
REQ-022 IDLE arbitration with only vc_req set SHALL go to VC_WB.
REQ-023 With both requests set in IDLE, L2_RD SHALL win unless starve_cnt == STARVE_LIMIT, in which case VC_WB SHALL win.
REQ-024 In L2_RD, the block SHALL drive pmem_read=1 and pmem_addr=l2_addr.
REQ-025 In L2_RD, on the pmem_resp cycle, the block SHALL assert l2_ack for that cycle only, l2_rdata SHALL equal pmem_rdata, and next state SHALL be IDLE.
REQ-026 In VC_WB, the block SHALL drive pmem_write=1, pmem_addr=vc_addr and pmem_wdata=vc_wdata.
REQ-027 In VC_WB, on the pmem_resp cycle, the block SHALL assert vc_ack for that cycle only, and next state SHALL be IDLE.
REQ-028 Outside the owning state, pmem_read, pmem_write, l2_ack and vc_ack SHALL be 0; pmem_addr and pmem_wdata are don't-care.
REQ-029 There SHALL be exactly one IDLE cycle between back-to-back grants; latency from request to strobe is 1 cycle.
REQ-030 pmem_resp seen in IDLE SHALL be ignored.
REQ-031 starve_cnt (3 bits) SHALL increment, saturating at STARVE_LIMIT, each time L2_RD is granted while vc_req=1.
REQ-032 starve_cnt SHALL clear on entry to VC_WB.
REQ-033 idle_cnt SHALL increment each cycle in IDLE with l2_read=0 and vc_req=0.
REQ-034 idle_cnt SHALL clear on any request or non-IDLE state.
REQ-035 When idle_cnt == IDLE_THRESH-1 and still idle, scrub_go SHALL pulse for 1 cycle and idle_cnt SHALL clear, so pulses recur every IDLE_THRESH idle cycles.
REQ-036 scrub_go SHALL be 0 whenever a request is present that cycle.
REQ-037 Requests dropped before ack are a protocol violation; behaviour is undefined.

Reset
REQ-038 rst_n=0 SHALL immediately force state IDLE, starve_cnt=0, idle_cnt=0, and pmem_read, pmem_write, l2_ack, vc_ack and scrub_go to 0, including mid-transaction.
REQ-039 After release, the first arbitration SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-040 l2_read=1 with addr 0x1230, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read high 3 cycles, then l2_ack one cycle with l2_rdata=0xA5..A5.
REQ-041 vc_req=1 with addr 0x4560 and wdata=0xFF..00 -> pmem_write high, pmem_addr=0x4560, vc_ack on resp.
REQ-042 l2_read and vc_req both held continuously -> L2 granted 4 times, then VC granted on the 5th grant, and starve_cnt returns to 0.
REQ-043 No requests for 20 cycles after reset -> scrub_go pulses on cycles 8 and 16 only.
REQ-044 Assert rst_n=0 mid-VC_WB -> pmem_write falls in the same cycle, and after release the pending vc_req is re-granted from IDLE.
REQ-045 pmem_resp pulsed while in IDLE -> no ack is generated and state is unchanged.

Source files
------------

// File: rtl/vc_pmem_arbiter_if.sv
// Bus bundle between the L2 fill port, the victim-cache writeback port,
// the scrub strobe and the physical memory port.
interface vc_pmem_arbiter_if;
    // L2 line-fill port
    logic         l2_read;
    logic [15:0]  l2_addr;
    logic [127:0] l2_rdata;
    logic         l2_ack;

    // Victim-cache writeback port
    logic         vc_req;
    logic [15:0]  vc_addr;
    logic [127:0] vc_wdata;
    logic         vc_ack;
    logic         scrub_go;

    // Physical memory port
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_addr;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    // The arbiter side
    modport slave (
        input  l2_read, l2_addr, vc_req, vc_addr, vc_wdata, pmem_resp, pmem_rdata,
        output l2_rdata, l2_ack, vc_ack, scrub_go,
               pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    // The requesters and the memory side
    modport master (
        output l2_read, l2_addr, vc_req, vc_addr, vc_wdata, pmem_resp, pmem_rdata,
        input  l2_rdata, l2_ack, vc_ack, scrub_go,
               pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/vc_pmem_arbiter.sv
// Physical-memory arbiter shared by the L2 fill path and the victim-cache
// writeback path. L2 fills normally win; a writeback that keeps losing is
// forced through after STARVE_LIMIT losses. Long idle stretches produce a
// scrub pulse so the victim cache can clean dirty entries in the background.
module vc_pmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int IDLE_THRESH  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    vc_pmem_arbiter_if.slave bus
);
    localparam int                IDLE_W     = (IDLE_THRESH > 1) ? $clog2(IDLE_THRESH) : 1;
    localparam logic [2:0]        STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_THRESH - 1);

    typedef enum logic [1:0] {
        IDLE,
        L2_RD,
        VC_WB
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          starve_cnt_q, starve_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                pmem_read_q, pmem_read_d;
    logic                pmem_write_q, pmem_write_d;
    logic                scrub_fire;

    // Arbitration, starvation tracking and idle/scrub counting.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        idle_cnt_d   = '0;
        scrub_fire   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.l2_read && !(bus.vc_req && starve_cnt_q == STARVE_MAX)) begin
                    state_d = L2_RD;
                    // The writeback only loses here while below the limit,
                    // so this increment saturates at STARVE_MAX by itself.
                    if (bus.vc_req) begin
                        starve_cnt_d = starve_cnt_q + 3'd1;
                    end
                end else if (bus.vc_req) begin
                    state_d      = VC_WB;
                    starve_cnt_d = 3'd0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    scrub_fire = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            L2_RD, VC_WB: begin
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pmem_read_d  = (state_d == L2_RD);
        pmem_write_d = (state_d == VC_WB);
    end

    // State and strobe registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= 3'd0;
            idle_cnt_q   <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
        end
    end

    // Strobes come from flops; acks follow pmem_resp in the same cycle.
    assign bus.pmem_read  = pmem_read_q;
    assign bus.pmem_write = pmem_write_q;
    assign bus.pmem_addr  = (state_q == VC_WB) ? bus.vc_addr : bus.l2_addr;
    assign bus.pmem_wdata = bus.vc_wdata;
    assign bus.l2_rdata   = bus.pmem_rdata;
    assign bus.l2_ack     = (state_q == L2_RD) && bus.pmem_resp;
    assign bus.vc_ack     = (state_q == VC_WB) && bus.pmem_resp;
    assign bus.scrub_go   = scrub_fire;

endmodule

// File: tb/tb_vc_pmem_arbiter.sv
// Self-checking bench for vc_pmem_arbiter: a transaction-level model of
// ownership, losses and quiet time is compared against the DUT every cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_vc_pmem_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int IDLE_THRESH  = 8;

    logic clk;
    logic rst_n;

    vc_pmem_arbiter_if bus ();

    vc_pmem_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .IDLE_THRESH  (IDLE_THRESH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Requesters: hold a request until its ack, then drop it unless more remain.
    int l2_left = 0;
    int vc_left = 0;
    initial begin
        logic l2_seen, vc_seen;
        bus.l2_read = 1'b0;
        bus.vc_req  = 1'b0;
        forever begin
            @(negedge clk);
            l2_seen = bus.l2_ack;
            vc_seen = bus.vc_ack;
            @(posedge clk);
            #1;
            if (l2_seen && l2_left > 0) l2_left--;
            if (vc_seen && vc_left > 0) vc_left--;
            bus.l2_read = (l2_left > 0);
            bus.vc_req  = (vc_left > 0);
        end
    end

    // Memory: answers after resp_wait strobe cycles, on the following cycle.
    int   resp_wait = 1;
    logic auto_resp;
    logic force_resp = 1'b0;
    assign bus.pmem_resp = auto_resp | force_resp;
    initial begin
        int strobe_cnt;
        strobe_cnt = 0;
        auto_resp  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_read || bus.pmem_write) begin
                if (strobe_cnt >= resp_wait) begin
                    auto_resp  = 1'b1;
                    strobe_cnt = 0;
                end else begin
                    auto_resp  = 1'b0;
                    strobe_cnt++;
                end
            end else begin
                auto_resp  = 1'b0;
                strobe_cnt = 0;
            end
        end
    end

    // Model: who owns memory (0 none, 1 L2, 2 VC), how often the pending
    // writeback has lost, and how long the bus has been quiet.
    int m_owner = 0;
    int m_losses = 0;
    int m_quiet = 0;
    int grants[$];
    logic prev_strobe = 1'b0;

    always @(negedge clk) begin
        logic any_req, e_scrub;
        if (!rst_n) begin
            m_owner  = 0;
            m_losses = 0;
            m_quiet  = 0;
        end
        any_req = bus.l2_read || bus.vc_req;
        e_scrub = (m_owner == 0) && !any_req && (m_quiet == IDLE_THRESH - 1);

        check("cyc pmem_read",  128'(bus.pmem_read),  128'(m_owner == 1));
        check("cyc pmem_write", 128'(bus.pmem_write), 128'(m_owner == 2));
        check("cyc l2_ack",     128'(bus.l2_ack),     128'((m_owner == 1) && bus.pmem_resp));
        check("cyc vc_ack",     128'(bus.vc_ack),     128'((m_owner == 2) && bus.pmem_resp));
        check("cyc scrub_go",   128'(bus.scrub_go),   128'(e_scrub));
        if (m_owner == 1) check("cyc l2 addr", 128'(bus.pmem_addr), 128'(bus.l2_addr));
        if (m_owner == 2) begin
            check("cyc vc addr",  128'(bus.pmem_addr), 128'(bus.vc_addr));
            check("cyc vc wdata", bus.pmem_wdata, bus.vc_wdata);
        end
        if (m_owner == 1 && bus.pmem_resp) check("cyc l2_rdata", bus.l2_rdata, bus.pmem_rdata);

        if ((bus.pmem_read || bus.pmem_write) && !prev_strobe) grants.push_back(bus.pmem_read ? 1 : 2);
        prev_strobe = bus.pmem_read || bus.pmem_write;

        if (rst_n) begin
            if (m_owner == 0) begin
                if (bus.l2_read && bus.vc_req) begin
                    if (m_losses == STARVE_LIMIT) begin
                        m_owner  = 2;
                        m_losses = 0;
                    end else begin
                        m_owner  = 1;
                        m_losses = (m_losses + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_losses + 1;
                    end
                end else if (bus.l2_read) begin
                    m_owner = 1;
                end else if (bus.vc_req) begin
                    m_owner  = 2;
                    m_losses = 0;
                end
                m_quiet = (any_req || e_scrub) ? 0 : m_quiet + 1;
            end else begin
                m_quiet = 0;
                if (bus.pmem_resp) m_owner = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int scrub_cycles[$];
        int n_strobe;
        bit got;

        rst_n          = 1'b0;
        bus.l2_addr    = 16'h0;
        bus.vc_addr    = 16'h0;
        bus.vc_wdata   = '0;
        bus.pmem_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset pmem_read",  128'(bus.pmem_read),  128'(0));
        check("reset pmem_write", 128'(bus.pmem_write), 128'(0));
        check("reset scrub_go",   128'(bus.scrub_go),   128'(0));
        check("reset acks",       128'({bus.l2_ack, bus.vc_ack}), 128'(0));

        // Scrub pulses on quiet cycles 8 and 16 after release
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (bus.scrub_go) scrub_cycles.push_back(cyc);
        end
        check("scrub count", 128'(scrub_cycles.size()), 128'(2));
        check("scrub first",  128'((scrub_cycles.size() > 0) ? scrub_cycles[0] : 0), 128'(8));
        check("scrub second", 128'((scrub_cycles.size() > 1) ? scrub_cycles[1] : 0), 128'(16));

        // pmem_resp while idle is ignored
        @(posedge clk);
        #1 force_resp = 1'b1;
        @(negedge clk);
        check("idle resp acks", 128'({bus.l2_ack, bus.vc_ack}), 128'(0));
        @(posedge clk);
        #1 force_resp = 1'b0;
        @(negedge clk);
        check("idle resp strobes", 128'({bus.pmem_read, bus.pmem_write}), 128'(0));

        // L2 fill: three strobe cycles, then ack with the read data
        bus.l2_addr    = 16'h1230;
        bus.pmem_rdata = {16{8'hA5}};
        resp_wait      = 3;
        l2_left        = 1;
        n_strobe = 0;
        got      = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.l2_ack) begin
                got = 1'b1;
                check("l2 rdata", bus.l2_rdata, {16{8'hA5}});
            end else if (bus.pmem_read) begin
                n_strobe++;
                check("l2 pmem_addr", 128'(bus.pmem_addr), 128'(16'h1230));
            end
        end
        if (!got) timeout_fail("l2 ack");
        check("l2 read cycles", 128'(n_strobe), 128'(3));
        repeat (3) @(negedge clk);

        // VC writeback
        bus.vc_addr  = 16'h4560;
        bus.vc_wdata = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        resp_wait    = 2;
        vc_left      = 1;
        n_strobe = 0;
        got      = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.vc_ack) got = 1'b1;
            if (bus.pmem_write && !got) begin
                n_strobe++;
                check("vc pmem_addr",  128'(bus.pmem_addr), 128'(16'h4560));
                check("vc pmem_wdata", bus.pmem_wdata, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
            end
        end
        if (!got) timeout_fail("vc ack");
        check("vc write cycles", 128'(n_strobe), 128'(2));
        repeat (3) @(negedge clk);

        // Both held: four L2 grants, then the writeback is forced through
        resp_wait = 1;
        grants.delete();
        l2_left = 5;
        vc_left = 1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (grants.size() == 4 && bus.pmem_read)
                check("starve at limit", 128'(dut.starve_cnt_q), 128'(STARVE_LIMIT));
            if (grants.size() >= 5) begin
                got = 1'b1;
                check("starve cleared", 128'(dut.starve_cnt_q), 128'(0));
            end
        end
        if (!got) timeout_fail("five grants");
        for (int g = 0; g < 5; g++)
            check($sformatf("grant %0d", g), 128'((grants.size() > g) ? grants[g] : 0), 128'((g == 4) ? 2 : 1));
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (l2_left == 0 && vc_left == 0 && !bus.pmem_read && !bus.pmem_write) got = 1'b1;
        end
        if (!got) timeout_fail("drain");
        check("starve after drain", 128'(dut.starve_cnt_q), 128'(0));
        repeat (2) @(negedge clk);

        // Reset in the middle of a writeback, then re-grant from IDLE
        bus.vc_addr  = 16'h0BE0;
        bus.vc_wdata = {8{16'h1234}};
        resp_wait    = 6;
        vc_left      = 1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.pmem_write) got = 1'b1;
        end
        if (!got) timeout_fail("vc strobe before reset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("reset drops pmem_write", 128'(bus.pmem_write), 128'(0));
        check("reset drops vc_ack",     128'(bus.vc_ack),     128'(0));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post-reset idle", 128'(bus.pmem_write), 128'(0));
        @(negedge clk);
        check("post-reset regrant", 128'(bus.pmem_write), 128'(1));
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.vc_ack) got = 1'b1;
        end
        if (!got) timeout_fail("vc ack after reset");
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
